// File: rtl/fp_to_twos_decoder.sv
// fp_to_twos_decoder
// Expands a compressed float {S, E, F} into an OUT_W-bit two's-complement
// value (-1)^S * F * 2^E. The significand is shifted left one bit per clock,
// E times, and the sign is applied afterwards. The block is not pipelined.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// SHIFT | shifting mag left while cnt != 0
// SIGN  | applying the sign, loading D
// DONE  | D valid, waiting for out_ready
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   S, E, F, in_valid     input sample and its valid
//   in_ready              high only in IDLE
//   D, out_valid          result (two's complement) and its valid
//   out_ready             consumer takes D
//
// Legal only if ((2^MAN_W)-1) << ((2^EXP_W)-1) < 2^(OUT_W-1).
module fp_to_twos_decoder #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic [EXP_W-1:0] E,
    input  logic [MAN_W-1:0] F,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] D,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [OUT_W-1:0] mag;
    logic [EXP_W-1:0] cnt;
    logic             sign;
    logic             cnt_tc;

    // cnt is a down-counter; terminal count ends the shift phase
    assign cnt_tc = (cnt == '0);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SHIFT;
            SHIFT:   if (cnt_tc) state_nx = SIGN;
            SIGN:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // datapath: latched sample, shifter, counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag  <= '0;
            cnt  <= '0;
            sign <= 1'b0;
            D    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag  <= {{(OUT_W-MAN_W){1'b0}}, F};
                        cnt  <= E;
                        sign <= S;
                    end
                end
                SHIFT: begin
                    if (!cnt_tc) begin
                        mag <= mag << 1;
                        cnt <= cnt - 1'b1;
                    end
                end
                SIGN: begin
                    // negating zero gives zero, so S=1,F=0 lands on D=0
                    D <= sign ? (~mag + OUT_W'(1)) : mag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_twos_decoder.sv
module tb_fp_to_twos_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        S = 1'b0;
    logic [2:0]  E = '0;
    logic [3:0]  F = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    fp_to_twos_decoder #(.EXP_W(3), .MAN_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .E         (E),
        .F         (F),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] d;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_d(input logic s, input logic [2:0] e, input logic [3:0] f);
        int v;
        v = int'(f) << e;
        if (s) v = -v;
        return v[11:0];
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after out_valid rose.
    task automatic convert(input logic s, input logic [2:0] e, input logic [3:0] f,
                           output int edges);
        chk("in_ready_before_accept", in_ready, 1'b1);
        S = s; E = e; F = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        S = ~s; E = ~e; F = ~f;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout: out_valid never rose for s=%0d e=%0d f=%0d", s, e, f);
        end
        @(negedge clk);
    endtask

    initial begin
        int edges;
        int q[$];
        int nin, nout, cyc;
        logic [7:0] code;

        vecs[0] = '{1'b0, 3'd0, 4'd1,  12'h001};
        vecs[1] = '{1'b1, 3'd7, 4'd15, 12'h880};
        vecs[2] = '{1'b1, 3'd3, 4'd0,  12'h000};
        vecs[3] = '{1'b0, 3'd4, 4'd9,  12'h090};
        vecs[4] = '{1'b1, 3'd0, 4'd1,  12'hFFF};
        vecs[5] = '{1'b0, 3'd7, 4'd15, 12'h780};
        vecs[6] = '{1'b1, 3'd2, 4'd3,  12'hFF4};
        vecs[7] = '{1'b0, 3'd5, 4'd1,  12'h020};
        vecs[8] = '{1'b1, 3'd6, 4'd5,  12'hEC0};
        vecs[9] = '{1'b0, 3'd2, 4'd0,  12'h000};

        #2;
        chk("reset_D", D, 12'h000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // table vectors, out_ready held high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            convert(vecs[i].s, vecs[i].e, vecs[i].f, edges);
            chk($sformatf("latency_v%0d", i), edges, vecs[i].e + 2);
            chk($sformatf("D_v%0d", i), D, vecs[i].d);
            @(posedge clk); #1;
            chk($sformatf("in_ready_after_v%0d", i), in_ready, 1'b1);
            chk($sformatf("out_valid_low_v%0d", i), out_valid, 1'b0);
            @(negedge clk);
        end

        // consumer stall with an ignored second request
        out_ready = 1'b0;
        convert(1'b0, 3'd4, 4'd9, edges);
        chk("stall_latency", edges, 6);
        for (int c = 0; c < 6; c++) begin
            S = 1'b1; E = 3'd1; F = 4'd2; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("stall_D", D, 12'h090);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", out_valid, 1'b0);
        chk("stall_release_in_ready", in_ready, 1'b1);
        chk("stall_release_D_held", D, 12'h090);
        @(negedge clk);

        // reset mid-conversion
        chk("abort_in_ready_before", in_ready, 1'b1);
        S = 1'b1; E = 3'd6; F = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_D", D, 12'h000);
        chk("abort_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) edges++;
        end
        chk("abort_no_stale_result", edges, 0);
        @(negedge clk);

        // back-to-back sweep of all codes with random out_ready
        nin = 0; nout = 0; cyc = 0;
        while (nout < 256 && cyc < 8000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (nin < 256) begin
                code = nin[7:0];
                S = code[7]; E = code[6:4]; F = code[3:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(int'(ref_d(S, E, F)));
                nin++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL sweep_extra_output: got %0h with no pending input", D);
                end else begin
                    chk($sformatf("sweep_D_%0d", nout), D, q.pop_front());
                end
                nout++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("sweep_in_count", nin, 256);
        chk("sweep_out_count", nout, nin);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
